// File: rtl/sram_arbiter_if.sv
// Bus bundle between the arbiter and its environment: fetch requester,
// data requester and the single-port SRAM. Signal names keep the
// requester/SRAM port naming so waveforms read the same as the block ports.
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
);
  // fetch requester
  logic                  i_req_i;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic                  i_gnt_o;
  logic                  i_rvalid_o;
  logic [DATA_WIDTH-1:0] i_rdata_o;

  // data requester
  logic                  d_req_i;
  logic                  d_we_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [DATA_WIDTH-1:0] d_wdata_i;
  logic [NUM_WMASKS-1:0] d_wmask_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [DATA_WIDTH-1:0] d_rdata_o;

  // SRAM macro
  logic                  sram_csb_o;
  logic                  sram_web_o;
  logic [ADDR_WIDTH-1:0] sram_addr_o;
  logic [DATA_WIDTH-1:0] sram_wdata_o;
  logic [NUM_WMASKS-1:0] sram_wmask_o;
  logic [DATA_WIDTH-1:0] sram_rdata_i;

  // arbiter side
  modport slave (
    input  i_req_i, i_addr_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wmask_i,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output sram_csb_o, sram_web_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
    input  sram_rdata_i
  );

  // requesters plus SRAM model side
  modport master (
    output i_req_i, i_addr_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wmask_i,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  sram_csb_o, sram_web_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
    output sram_rdata_i
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM. Data wins ties
// unless the fetch port has been passed over STARVE_LIMIT times in a row.
// Grants are combinational; responses return exactly one cycle later,
// steered by a one-entry in-flight register.
module sram_arbiter #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WMASKS   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sram_arbiter_if.slave        bus,
  output logic [15:0]          conflict_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        inflight_valid_q, inflight_valid_d;
  owner_e      inflight_owner_q, inflight_owner_d;
  logic        inflight_write_q, inflight_write_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  logic i_gnt;
  logic d_gnt;
  logic both_req;

  assign both_req = bus.i_req_i && bus.d_req_i;

  // Arbitration; gated by rst_ni so no grant escapes while reset is held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_ni) begin
      if (both_req) begin
        if (starve_cnt_q == LIMIT) i_gnt = 1'b1;
        else                       d_gnt = 1'b1;
      end else if (bus.i_req_i) begin
        i_gnt = 1'b1;
      end else if (bus.d_req_i) begin
        d_gnt = 1'b1;
      end
    end
  end

  // SRAM drive: the winner's payload, everything parked when idle.
  always_comb begin
    bus.sram_csb_o   = 1'b1;
    bus.sram_web_o   = 1'b1;
    bus.sram_addr_o  = '0;
    bus.sram_wdata_o = '0;
    bus.sram_wmask_o = '0;
    if (i_gnt) begin
      bus.sram_csb_o  = 1'b0;
      bus.sram_addr_o = bus.i_addr_i;
    end else if (d_gnt) begin
      bus.sram_csb_o   = 1'b0;
      bus.sram_web_o   = !bus.d_we_i;
      bus.sram_addr_o  = bus.d_addr_i;
      bus.sram_wdata_o = bus.d_wdata_i;
      bus.sram_wmask_o = bus.d_wmask_i;
    end
  end

  // Next-state for the starvation counter, in-flight entry and conflict counter.
  always_comb begin
    starve_cnt_d     = starve_cnt_q;
    inflight_valid_d = i_gnt || d_gnt;
    inflight_owner_d = d_gnt ? OWN_DATA : OWN_FETCH;
    inflight_write_d = d_gnt && bus.d_we_i;
    conflict_cnt_d   = conflict_cnt_q;

    // Only data grants that pass over a waiting fetch count toward starvation.
    if (i_gnt || !bus.i_req_i) begin
      starve_cnt_d = '0;
    end else if (d_gnt && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    if (both_req && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // State registers; async reset also drops any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q     <= '0;
      inflight_valid_q <= 1'b0;
      inflight_owner_q <= OWN_FETCH;
      inflight_write_q <= 1'b0;
      conflict_cnt_q   <= '0;
    end else begin
      starve_cnt_q     <= starve_cnt_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_owner_q <= inflight_owner_d;
      inflight_write_q <= inflight_write_d;
      conflict_cnt_q   <= conflict_cnt_d;
    end
  end

  // Response steering: read data only reaches the owner; write acks carry zero data.
  always_comb begin
    bus.i_gnt_o    = i_gnt;
    bus.d_gnt_o    = d_gnt;
    bus.i_rvalid_o = inflight_valid_q && (inflight_owner_q == OWN_FETCH);
    bus.d_rvalid_o = inflight_valid_q && (inflight_owner_q == OWN_DATA);
    bus.i_rdata_o  = bus.i_rvalid_o ? bus.sram_rdata_i : '0;
    bus.d_rdata_o  = (bus.d_rvalid_o && !inflight_write_q) ? bus.sram_rdata_i : '0;
    conflict_cnt_o = conflict_cnt_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus checks grants/SRAM drive and
// queues the expected response; a negedge monitor pops and compares rdata.
module tb_sram_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) bus ();

  sram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW), .STARVE_LIMIT(4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus),
    .conflict_cnt_o(conflict_cnt)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic        prev_ig = 1'b0;
  logic        prev_dg = 1'b0;
  bit          verbose = 1'b1;
  logic [31:0] mem [0:8191];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // SRAM model: masked write, read data registered one cycle after the access edge.
  always @(posedge clk) begin
    if (!bus.sram_csb_o) begin
      if (!bus.sram_web_o) begin
        for (int b = 0; b < MW; b++) begin
          if (bus.sram_wmask_o[b]) mem[bus.sram_addr_o][8*b +: 8] <= bus.sram_wdata_o[8*b +: 8];
        end
      end
      bus.sram_rdata_i <= mem[bus.sram_addr_o];
    end
  end

  // Response monitor
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      check("rvalid_exclusive", 32'(bus.i_rvalid_o & bus.d_rvalid_o), 32'd0);
      if (bus.i_rvalid_o) begin
        if (exp_i_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL i_rvalid_unexpected: got rvalid=1, expected none");
        end else begin
          e = exp_i_q.pop_front();
          check("i_rdata", bus.i_rdata_o, e);
          if (verbose) $display("fetch rsp: rdata=0x%08h exp=0x%08h", bus.i_rdata_o, e);
        end
      end else begin
        check("i_rdata_idle", bus.i_rdata_o, 32'd0);
      end
      if (bus.d_rvalid_o) begin
        if (exp_d_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL d_rvalid_unexpected: got rvalid=1, expected none");
        end else begin
          e = exp_d_q.pop_front();
          check("d_rdata", bus.d_rdata_o, e);
          if (verbose) $display("data rsp: rdata=0x%08h exp=0x%08h", bus.d_rdata_o, e);
        end
      end else begin
        check("d_rdata_idle", bus.d_rdata_o, 32'd0);
      end
    end
  end

  // One cycle of stimulus: drive, check grant and SRAM drive, queue the expected response.
  task automatic access(input string tag, input logic ireq, input logic [AW-1:0] iaddr,
                        input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                        input logic [DW-1:0] wdata, input logic [MW-1:0] wmask,
                        input logic exp_ig, input logic exp_dg, input logic [DW-1:0] exp_rd);
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic [MW-1:0] em;
    bus.i_req_i   = ireq;
    bus.i_addr_i  = iaddr;
    bus.d_req_i   = dreq;
    bus.d_we_i    = dwe;
    bus.d_addr_i  = daddr;
    bus.d_wdata_i = wdata;
    bus.d_wmask_i = wmask;
    @(negedge clk);
    ea = exp_ig ? iaddr : (exp_dg ? daddr : '0);
    ew = exp_dg ? wdata : '0;
    em = exp_dg ? wmask : '0;
    check({tag, ".i_gnt"}, 32'(bus.i_gnt_o), 32'(exp_ig));
    check({tag, ".d_gnt"}, 32'(bus.d_gnt_o), 32'(exp_dg));
    check({tag, ".csb"}, 32'(bus.sram_csb_o), 32'(!(exp_ig || exp_dg)));
    check({tag, ".web"}, 32'(bus.sram_web_o), 32'(!(exp_dg && dwe)));
    check({tag, ".addr"}, 32'(bus.sram_addr_o), 32'(ea));
    check({tag, ".wdata"}, bus.sram_wdata_o, ew);
    check({tag, ".wmask"}, 32'(bus.sram_wmask_o), 32'(em));
    check({tag, ".i_rvalid"}, 32'(bus.i_rvalid_o), 32'(prev_ig));
    check({tag, ".d_rvalid"}, 32'(bus.d_rvalid_o), 32'(prev_dg));
    if (exp_ig) exp_i_q.push_back(exp_rd);
    if (exp_dg) exp_d_q.push_back(dwe ? 32'd0 : exp_rd);
    prev_ig = exp_ig;
    prev_dg = exp_dg;
    if (verbose)
      $display("txn %s: ireq=%0b dreq=%0b we=%0b gnt i/d=%0b/%0b", tag, ireq, dreq, dwe,
               bus.i_gnt_o, bus.d_gnt_o);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    access(tag, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic drain_check(input string tag);
    idle(tag);
    idle(tag);
    check({tag, ".i_q_empty"}, 32'(exp_i_q.size()), 32'd0);
    check({tag, ".d_q_empty"}, 32'(exp_d_q.size()), 32'd0);
    exp_i_q.delete();
    exp_d_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req_i = 1'b0;
    bus.d_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_ig = 1'b0;
    prev_dg = 1'b0;
  endtask

  // Outputs while reset is held, with requests deliberately asserted.
  task automatic check_reset_outputs(input string tag, input logic [15:0] was_cnt);
    check({tag, ".i_gnt"}, 32'(bus.i_gnt_o), 32'd0);
    check({tag, ".d_gnt"}, 32'(bus.d_gnt_o), 32'd0);
    check({tag, ".i_rvalid"}, 32'(bus.i_rvalid_o), 32'd0);
    check({tag, ".d_rvalid"}, 32'(bus.d_rvalid_o), 32'd0);
    check({tag, ".i_rdata"}, bus.i_rdata_o, 32'd0);
    check({tag, ".d_rdata"}, bus.d_rdata_o, 32'd0);
    check({tag, ".csb"}, 32'(bus.sram_csb_o), 32'd1);
    check({tag, ".web"}, 32'(bus.sram_web_o), 32'd1);
    check({tag, ".addr"}, 32'(bus.sram_addr_o), 32'd0);
    check({tag, ".wdata"}, bus.sram_wdata_o, 32'd0);
    check({tag, ".wmask"}, 32'(bus.sram_wmask_o), 32'd0);
    check({tag, ".conflict"}, 32'(conflict_cnt), 32'd0);
    $display("reset check %s (counter before reset 0x%04h)", tag, was_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] cnt_before;
    for (int i = 0; i < 8192; i++) mem[i] <= 32'hA000_0000 | 32'(i);
    mem[13'h010] <= 32'hDEAD_BEEF;
    mem[13'h020] <= 32'h0000_0000;
    bus.sram_rdata_i <= '0;

    // Reset state with both requests and a nonzero payload presented.
    rst_n = 1'b0;
    bus.i_req_i   = 1'b1;
    bus.i_addr_i  = 13'h010;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 13'h020;
    bus.d_wdata_i = 32'hFFFF_FFFF;
    bus.d_wmask_i = 4'hF;
    #12;
    check_reset_outputs("por", 16'h0000);
    do_reset();

    // Fetch alone.
    access("fetch", 1'b1, 13'h010, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    idle("idle_after_fetch");

    // Data write then read back with a partial mask.
    access("wr", 1'b0, '0, 1'b1, 1'b1, 13'h020, 32'h1234_5678, 4'b0011, 1'b0, 1'b1, '0);
    access("rd", 1'b0, '0, 1'b1, 1'b0, 13'h020, '0, '0, 1'b0, 1'b1, 32'h0000_5678);

    // Back-to-back data reads, no bubbles.
    for (int a = 0; a < 5; a++)
      access("b2b", 1'b0, '0, 1'b1, 1'b0, 13'(a), '0, '0, 1'b0, 1'b1, 32'hA000_0000 | 32'(a));
    drain_check("basic");

    // Contention: D,D,D,D,I repeating.
    do_reset();
    for (int k = 0; k < 10; k++)
      access("contend", 1'b1, 13'h010, 1'b1, 1'b0, 13'h030, '0, '0,
             (k % 5) == 4, (k % 5) != 4, ((k % 5) == 4) ? 32'hDEAD_BEEF : 32'hA000_0030);
    idle("contend_end");
    check("contend.conflict", 32'(conflict_cnt), 32'd10);
    drain_check("contend");

    // Reset asserted before the edge that would launch a fetch.
    cnt_before = conflict_cnt;
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 13'h010;
    @(negedge clk);
    check("midflight.i_gnt", 32'(bus.i_gnt_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midflight", cnt_before);
    @(posedge clk);
    #1;
    bus.i_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_ig = 1'b0;
    prev_dg = 1'b0;
    idle("post_reset");
    idle("post_reset");

    // Conflict counter saturation.
    do_reset();
    verbose = 1'b0;
    for (int k = 0; k < 65535; k++)
      access("sat", 1'b1, 13'h010, 1'b1, 1'b0, 13'h030, '0, '0,
             (k % 5) == 4, (k % 5) != 4, ((k % 5) == 4) ? 32'hDEAD_BEEF : 32'hA000_0030);
    check("sat.at_ffff", 32'(conflict_cnt), 32'h0000_FFFF);
    for (int k = 65535; k < 65555; k++)
      access("sat", 1'b1, 13'h010, 1'b1, 1'b0, 13'h030, '0, '0,
             (k % 5) == 4, (k % 5) != 4, ((k % 5) == 4) ? 32'hDEAD_BEEF : 32'hA000_0030);
    check("sat.held", 32'(conflict_cnt), 32'h0000_FFFF);
    verbose = 1'b1;
    drain_check("sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
